wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline interface: the write-back stage fused with the architectural integer register file.
- Takes the latched MEM/WB fields, selects the write-back source, and commits the result into a 32-entry XLEN-wide register file.
- Serves two combinational read ports to the decode stage and exposes the write-back value for forwarding.
- Maintains a 64-bit retired-instruction counter for CSR instret.

Parameters:
XLEN, `XLEN, data width: 32 or 64 bits

Ports:
clk  input  1  clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
alu_result_in  input  XLEN  ALU result from MEM/WB
mem_read_data_in  input  XLEN  load data from MEM/WB
pc_plus_4_in  input  XLEN  link address from MEM/WB
csr_rdata_in  input  XLEN  CSR read data from MEM/WB
rd_addr_in  input  5  destination register
reg_write_in  input  1  write request
wb_sel_in  input  2  write-back source select
valid_in  input  1  instruction in WB is valid (retires this cycle)
rs1_addr  input  5  read port 1 address
rs2_addr  input  5  read port 2 address
rs1_data  output  XLEN  read port 1 data
rs2_data  output  XLEN  read port 2 data
wb_data_out  output  XLEN  selected write-back value (for forwarding)
wb_rd_out  output  5  equals rd_addr_in
wb_we_out  output  1  effective write enable
retire_count  output  64  retired-instruction count

Behaviour:
- Single clock clk; reset_n is asynchronous, active-low.
- wb_sel_in decode:
  - 2'b00: alu_result_in
  - 2'b01: mem_read_data_in
  - 2'b10: pc_plus_4_in
  - 2'b11: csr_rdata_in
  - wb_data_out is combinational from these.
- wb_we_out = valid_in & reg_write_in & (rd_addr_in != 0). This is combinational; wb_rd_out is a pass-through.
- Write: at posedge clk, if wb_we_out, regs[rd_addr_in] <= wb_data_out. Latency is 1 cycle to storage.
- x0: never written. Reads of address 0 return 0 regardless of bypass or any write attempt.
- Read ports: combinational from storage, plus the bypass rule in Optional Feature.
- Both read ports addressing the same register return identical data.
- retire_count increments by 1 at each posedge where valid_in=1, independent of reg_write_in. It wraps from 2^64-1 to 0.
- Reset (asynchronous, immediate):
  - registers x1..x31 = 0
  - retire_count = 0
  - combinational outputs then reflect reset state: rs*_data = 0
- reset_n asserted mid-write: the write is lost, the register reads 0 after release, and the counter restarts from 0.
- valid_in=0 with reg_write_in=1 (bubble): no write, no retire.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined:
  - When wb_we_out=1 and rsN_addr==rd_addr_in (nonzero), rsN_data = wb_data_out in the same cycle (write-through read).
  - Removes the need for a separate WB->ID forwarding path.
- Undefined:
  - Reads return pre-write storage contents during the write cycle. The new value is visible from the next cycle.
  - The hazard unit must then cover the WB->ID distance.

Test Plan:
- Reset with values pre-written, then release -> all rs*_data = 0, retire_count = 0.
- valid=1, reg_write=1, rd=5, wb_sel=00, alu=0xDEADBEEF; next cycle rs1_addr=5 -> rs1_data=0xDEADBEEF, retire_count=1.
- Cycle through wb_sel 01/10/11 with distinct values (0x11, 0x22, 0x33) to rd=1,2,3 -> readback returns the matching source. Also attempt a write of 0xFFFF to rd=0 -> x0 reads 0, wb_we_out=0.
- Same-cycle write rd=7 <- 0xA5A5 with rs1_addr=rs2_addr=7, old x7=0x1:
  - RF_WB_BYPASS_EN defined -> both read 0xA5A5.
  - Undefined -> both read 0x1, then 0xA5A5 next cycle.
- Bubble (valid=0, reg_write=1, rd=4, data 0x99) -> x4 unchanged, retire_count unchanged. valid=1 with reg_write=0 -> count+1, no write.
- Force retire_count near 2^64-1 (or via a long run in XLEN=32 sim with a backdoor), then one retire -> count=0. Assert reset_n mid-cycle during a write -> storage 0 immediately.

Source files
------------

// File: rtl/wb_regfile.sv
// Write-back stage fused with the 32 x XLEN integer register file and the instret counter.
// Optional macro RF_WB_BYPASS_EN: same-cycle write-through on the read ports.
module wb_regfile #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] mem_read_data_in,
  input  logic [XLEN-1:0] pc_plus_4_in,
  input  logic [XLEN-1:0] csr_rdata_in,
  input  logic [4:0]      rd_addr_in,
  input  logic            reg_write_in,
  input  logic [1:0]      wb_sel_in,
  input  logic            valid_in,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] wb_data_out,
  output logic [4:0]      wb_rd_out,
  output logic            wb_we_out,
  output logic [63:0]     retire_count
);

  logic [XLEN-1:0] r_regs [32];
  logic [63:0]     r_retire_count;
  logic [XLEN-1:0] w_wb_data;
  logic            w_we;

  always_comb begin
    w_wb_data = '0;
    unique case (wb_sel_in)
      2'b00:   w_wb_data = alu_result_in;
      2'b01:   w_wb_data = mem_read_data_in;
      2'b10:   w_wb_data = pc_plus_4_in;
      default: w_wb_data = csr_rdata_in;
    endcase
  end

  // rd == 0 is folded in here so x0 is never written and never bypassed.
  assign w_we        = valid_in & reg_write_in & (rd_addr_in != 5'd0);
  assign wb_data_out = w_wb_data;
  assign wb_we_out   = w_we;
  assign wb_rd_out   = rd_addr_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[rd_addr_in] <= w_wb_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_retire_count <= '0;
    end else if (valid_in) begin
      r_retire_count <= r_retire_count + 64'd1;
    end
  end

  assign retire_count = r_retire_count;

  always_comb begin
    rs1_data = (rs1_addr == 5'd0) ? '0 : r_regs[rs1_addr];
    rs2_data = (rs2_addr == 5'd0) ? '0 : r_regs[rs2_addr];
`ifdef RF_WB_BYPASS_EN
    if (w_we && (rs1_addr == rd_addr_in)) rs1_data = w_wb_data;
    if (w_we && (rs2_addr == rd_addr_in)) rs2_data = w_wb_data;
`endif
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, hand sequences, random vs. model.
module tb_wb_regfile;
  localparam int unsigned XLEN = 32;
`ifdef RF_WB_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic [XLEN-1:0] alu, mem, pc4, csr;
  logic [4:0]      rd, rs1, rs2;
  logic            we, valid;
  logic [1:0]      sel;
  logic [XLEN-1:0] rs1_data, rs2_data, wb_data;
  logic [4:0]      wb_rd;
  logic            wb_we;
  logic [63:0]     cnt;

  int total = 0;
  int bad   = 0;

  wb_regfile #(.XLEN(XLEN)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .alu_result_in    (alu),
    .mem_read_data_in (mem),
    .pc_plus_4_in     (pc4),
    .csr_rdata_in     (csr),
    .rd_addr_in       (rd),
    .reg_write_in     (we),
    .wb_sel_in        (sel),
    .valid_in         (valid),
    .rs1_addr         (rs1),
    .rs2_addr         (rs2),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .wb_data_out      (wb_data),
    .wb_rd_out        (wb_rd),
    .wb_we_out        (wb_we),
    .retire_count     (cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [1:0] s, input logic [4:0] d,
                       input logic [31:0] a, input logic [31:0] m, input logic [31:0] p,
                       input logic [31:0] c, input logic [4:0] r1, input logic [4:0] r2);
    valid = v; we = w; sel = s; rd = d;
    alu = a; mem = m; pc4 = p; csr = c;
    rs1 = r1; rs2 = r2;
  endtask

  typedef struct {
    logic        valid;
    logic        we;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        exp_we;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
    logic [63:0] exp_cnt;
  } vec_t;

  vec_t tv[8];

  // Behavioural model for the random phase.
  logic [31:0] m_regs [32];
  logic [63:0] m_cnt;

  function automatic logic [31:0] m_read(input logic [4:0] a, input logic [31:0] wbv,
                                         input logic wev, input logic [4:0] rdv);
    if (a == 5'd0) return 32'h0;
    if (Byp && wev && (a == rdv)) return wbv;
    return m_regs[a];
  endfunction

  initial begin
    logic [31:0] e_wb;
    logic        e_we;

    tv[0] = '{1'b1, 1'b1, 2'b00, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 1'b1, 32'h0, 32'h0, 64'd0};
    tv[1] = '{1'b1, 1'b1, 2'b01, 5'd1, 32'h11, 5'd5, 5'd5, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 64'd1};
    tv[2] = '{1'b1, 1'b1, 2'b10, 5'd2, 32'h22, 5'd1, 5'd5, 1'b1, 32'h11, 32'hDEADBEEF, 64'd2};
    tv[3] = '{1'b1, 1'b1, 2'b11, 5'd3, 32'h33, 5'd2, 5'd1, 1'b1, 32'h22, 32'h11, 64'd3};
    tv[4] = '{1'b1, 1'b1, 2'b00, 5'd0, 32'hFFFF, 5'd3, 5'd0, 1'b0, 32'h33, 32'h0, 64'd4};
    tv[5] = '{1'b0, 1'b1, 2'b00, 5'd4, 32'h99, 5'd0, 5'd3, 1'b0, 32'h0, 32'h33, 64'd5};
    tv[6] = '{1'b1, 1'b0, 2'b00, 5'd4, 32'h77, 5'd4, 5'd0, 1'b0, 32'h0, 32'h0, 64'd5};
    tv[7] = '{1'b0, 1'b0, 2'b01, 5'd6, 32'h55, 5'd4, 5'd5, 1'b0, 32'h0, 32'hDEADBEEF, 64'd6};

    reset_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd31);
    repeat (2) @(negedge clk);
    #1;
    check("reset_rs1", rs1_data, 32'h0);
    check("reset_rs2", rs2_data, 32'h0);
    check("reset_cnt", cnt, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed table; unselected sources carry junk so a wrong mux leg shows up.
    for (int i = 0; i < 8; i++) begin
      drive(tv[i].valid, tv[i].we, tv[i].sel, tv[i].rd,
            (tv[i].sel == 2'b00) ? tv[i].data : 32'hA1A10000 + i,
            (tv[i].sel == 2'b01) ? tv[i].data : 32'hB2B20000 + i,
            (tv[i].sel == 2'b10) ? tv[i].data : 32'hC3C30000 + i,
            (tv[i].sel == 2'b11) ? tv[i].data : 32'hD4D40000 + i,
            tv[i].rs1, tv[i].rs2);
      #1;
      check($sformatf("tv%0d_wb", i), wb_data, tv[i].data);
      check($sformatf("tv%0d_we", i), wb_we, tv[i].exp_we);
      check($sformatf("tv%0d_rd", i), wb_rd, tv[i].rd);
      check($sformatf("tv%0d_rs1", i), rs1_data, tv[i].exp_rs1);
      check($sformatf("tv%0d_rs2", i), rs2_data, tv[i].exp_rs2);
      check($sformatf("tv%0d_cnt", i), cnt, tv[i].exp_cnt);
      @(negedge clk);
    end

    // Same-cycle write/read of x7.
    drive(1'b1, 1'b1, 2'b00, 5'd7, 32'h1, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b00, 5'd7, 32'hA5A5, 32'h0, 32'h0, 32'h0, 5'd7, 5'd7);
    #1;
    check("byp_rs1", rs1_data, Byp ? 32'hA5A5 : 32'h1);
    check("byp_rs2", rs2_data, Byp ? 32'hA5A5 : 32'h1);
    @(negedge clk);
    valid = 1'b0;
    #1;
    check("byp_next_rs1", rs1_data, 32'hA5A5);
    check("byp_next_rs2", rs2_data, 32'hA5A5);
    check("byp_cnt", cnt, 64'd8);

    // Counter wrap via backdoor preload.
    @(negedge clk);
    dut.r_retire_count = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(1'b1, 1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd9);
    #1;
    check("wrap_pre", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    valid = 1'b0;
    #1;
    check("wrap_post", cnt, 64'd0);

    // Asynchronous reset in the middle of a write to x9.
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b00, 5'd9, 32'h1234, 32'h0, 32'h0, 32'h0, 5'd5, 5'd9);
    #1;
    check("midrst_pre_rs1", rs1_data, 32'hDEADBEEF);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_rs1", rs1_data, 32'h0);
    check("midrst_rs2", rs2_data, 32'h0);
    check("midrst_cnt", cnt, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    valid = 1'b0;
    #1;
    check("midrst_x9", rs2_data, 32'h0);
    check("midrst_x5", rs1_data, 32'h0);
    check("midrst_cnt_after", cnt, 64'd0);
    @(negedge clk);

    // Random phase against the model.
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_cnt = 64'd0;
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)), $urandom, $urandom, $urandom, $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) rs1 = rd;
      if ($urandom_range(0, 3) == 0) rs2 = rd;
      case (sel)
        2'b00:   e_wb = alu;
        2'b01:   e_wb = mem;
        2'b10:   e_wb = pc4;
        default: e_wb = csr;
      endcase
      e_we = valid && we && (rd != 5'd0);
      #1;
      check("rnd_wb", wb_data, e_wb);
      check("rnd_we", wb_we, e_we);
      check("rnd_rs1", rs1_data, m_read(rs1, e_wb, e_we, rd));
      check("rnd_rs2", rs2_data, m_read(rs2, e_wb, e_we, rd));
      check("rnd_cnt", cnt, m_cnt);
      @(posedge clk);
      if (e_we) m_regs[rd] = e_wb;
      if (valid) m_cnt = m_cnt + 64'd1;
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
